// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
// Holds the state enum, opcode constants, ALUOp codes and ALU operand-select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_EXEC_R   = 4'h2,
        S_EXEC_I   = 4'h3,
        S_WB_ALU   = 4'h4,
        S_MEM_ADDR = 4'h5,
        S_MEM_RD   = 4'h6,
        S_MEM_WR   = 4'h7,
        S_WB_MEM   = 4'h8,
        S_BRANCH   = 4'h9,
        S_HALT     = 4'hF
    } state_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // States in which the FSM holds mem_req and waits for mem_ready.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive memory wait cycles within one state; o_expire flags the
// cycle on which the MAX_WAIT-th wait cycle would pass with mem_ready still low.
module mem_wait_watchdog #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_count && (r_cnt == LAST);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core, with memory-wait watchdog and instret.
// Define ILLEGAL_TRAP_EN to halt on illegal opcodes and expose a sticky illegal_instr flag.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal_instr,
`endif
    output logic [3:0]       state_o
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             r_bus_err;
    logic [1:0]       w_alu_op, w_src_a, w_src_b;
    logic             w_pc_write, w_pc_src, w_ir_write, w_mem_req, w_mem_we;
    logic             w_reg_write, w_mem_to_reg;
    logic             w_retire, w_bus_err_set, w_illegal;
    logic             w_count, w_clear, w_expire;

    assign w_count = is_mem_wait_state(r_state) && !mem_ready;
    assign w_clear = (w_next != r_state);

    generate
        if (MAX_WAIT == 0) begin : g_no_watchdog
            assign w_expire = 1'b0;
        end else begin : g_watchdog
            mem_wait_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
                .clk      (clk),
                .rst      (rst),
                .i_clear  (w_clear),
                .i_count  (w_count),
                .o_expire (w_expire)
            );
        end
    endgenerate

    always_comb begin
        w_next        = r_state;
        w_alu_op      = ALUOP_ADD;
        w_src_a       = SRC_A_PC;
        w_src_b       = SRC_B_RS2;
        w_pc_write    = 1'b0;
        w_pc_src      = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_retire      = 1'b0;
        w_bus_err_set = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_src_b   = SRC_B_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_expire) begin
                    w_bus_err_set = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                w_src_a = SRC_A_OLD_PC;
                w_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R_TYPE:         w_next = S_EXEC_R;
                    OP_I_TYPE:         w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        w_next = S_HALT;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                w_src_a  = SRC_A_RS1;
                w_src_b  = SRC_B_RS2;
                w_alu_op = ALUOP_R;
                w_next   = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_src_a  = SRC_A_RS1;
                w_src_b  = SRC_B_IMM;
                w_alu_op = ALUOP_I;
                w_next   = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_src_a = SRC_A_RS1;
                w_src_b = SRC_B_IMM;
                w_next  = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_expire) begin
                    w_bus_err_set = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_expire) begin
                    w_bus_err_set = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a    = SRC_A_RS1;
                w_src_b    = SRC_B_RS2;
                w_alu_op   = ALUOP_SUB;
                w_pc_src   = 1'b1;
                w_pc_write = zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_bus_err_set) begin
                r_bus_err <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_instr = r_illegal;
`else
    logic w_illegal_unused;
    assign w_illegal_unused = w_illegal;
`endif

    // Gate with rst so an abandoned request drops in the same cycle reset rises.
    assign alu_op     = rst ? 2'b00 : w_alu_op;
    assign alu_src_a  = rst ? 2'b00 : w_src_a;
    assign alu_src_b  = rst ? 2'b00 : w_src_b;
    assign pc_write   = !rst && w_pc_write;
    assign pc_src     = !rst && w_pc_src;
    assign ir_write   = !rst && w_ir_write;
    assign mem_req    = !rst && w_mem_req;
    assign mem_we     = !rst && w_mem_we;
    assign reg_write  = !rst && w_reg_write;
    assign mem_to_reg = !rst && w_mem_to_reg;
    assign halted     = !rst && (r_state == S_HALT);
    assign bus_err    = !rst && r_bus_err;
    assign instret    = r_instret;
    assign state_o    = r_state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized self-checking bench for riscv_multicycle_ctrl against a per-instruction cycle model.
// Also exercises the watchdog, illegal opcodes (ILLEGAL_TRAP_EN aware) and reset mid-store.
module tb_riscv_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic [1:0]    alu_op, alu_src_a, alu_src_b;
    logic          pc_write, pc_src, ir_write, mem_req, mem_we;
    logic          reg_write, mem_to_reg, halted, bus_err;
    logic [CW-1:0] instret;
    logic [3:0]    state_o;
`ifdef ILLEGAL_TRAP_EN
    logic          illegal_instr;
`endif

    riscv_multicycle_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .halted        (halted),
        .bus_err       (bus_err),
        .instret       (instret),
`ifdef ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    logic [31:0] obs;
    assign obs = {13'd0, state_o, alu_op, alu_src_a, alu_src_b, pc_write, pc_src,
                  ir_write, mem_req, mem_we, reg_write, mem_to_reg, halted, bus_err};

    int n_checks = 0;
    int n_pass   = 0;
    int model_instret = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected observation vector: state, ALU controls, then single-bit controls.
    function automatic logic [31:0] v(input logic [3:0] st, input logic [1:0] op,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic pcw, input logic pcs, input logic irw,
                                      input logic mrq, input logic mwe, input logic rw,
                                      input logic m2r, input logic hl, input logic be);
        return {13'd0, st, op, a, b, pcw, pcs, irw, mrq, mwe, rw, m2r, hl, be};
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, return #1 after the next edge.
    task automatic cyc(input logic mr, input logic z, input logic [31:0] exp, input string tag);
        mem_ready = mr;
        zero      = z;
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", obs, 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
        rst = 1'b0;
        model_instret = 0;
    endtask

    function automatic logic legal_op(input logic [6:0] o);
        return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
               o == 7'b0100011 || o == 7'b1100011;
    endfunction

    function automatic logic [6:0] op_of(input int kind);
        logic [6:0] o;
        case (kind)
            0: o = 7'b0110011;
            1: o = 7'b0010011;
            2: o = 7'b0000011;
            3: o = 7'b0100011;
            4: o = 7'b1100011;
            default: begin
                o = 7'($urandom_range(0, 127));
                if (legal_op(o)) o = 7'b1111111;
            end
        endcase
        return o;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Fetch + decode common to every instruction.
    task automatic front_end(input int fwait);
        for (int i = 0; i < fwait; i++)
            cyc(1'b0, rnd(), v(S_FETCH, 2'b00, 2'b00, 2'b01, 0,0,0,1,0,0,0,0,0), "fetch_wait");
        cyc(1'b1, rnd(), v(S_FETCH, 2'b00, 2'b00, 2'b01, 1,0,1,1,0,0,0,0,0), "fetch_done");
        cyc(rnd(), rnd(), v(S_DECODE, 2'b00, 2'b10, 2'b10, 0,0,0,0,0,0,0,0,0), "decode");
    endtask

    // kinds: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 illegal (NOP path)
    task automatic run_instr(input int kind, input int fwait, input int mwait, input logic z);
        opcode = op_of(kind);
        front_end(fwait);
        case (kind)
            0: begin
                cyc(rnd(), rnd(), v(S_EXEC_R, 2'b10, 2'b01, 2'b00, 0,0,0,0,0,0,0,0,0), "exec_r");
                cyc(rnd(), rnd(), v(S_WB_ALU, 2'b00, 2'b00, 2'b00, 0,0,0,0,0,1,0,0,0), "wb_alu");
            end
            1: begin
                cyc(rnd(), rnd(), v(S_EXEC_I, 2'b11, 2'b01, 2'b10, 0,0,0,0,0,0,0,0,0), "exec_i");
                cyc(rnd(), rnd(), v(S_WB_ALU, 2'b00, 2'b00, 2'b00, 0,0,0,0,0,1,0,0,0), "wb_alu");
            end
            2: begin
                cyc(rnd(), rnd(), v(S_MEM_ADDR, 2'b00, 2'b01, 2'b10, 0,0,0,0,0,0,0,0,0), "mem_addr");
                for (int i = 0; i < mwait; i++)
                    cyc(1'b0, rnd(), v(S_MEM_RD, 2'b00, 2'b00, 2'b00, 0,0,0,1,0,0,0,0,0), "mem_rd_wait");
                cyc(1'b1, rnd(), v(S_MEM_RD, 2'b00, 2'b00, 2'b00, 0,0,0,1,0,0,0,0,0), "mem_rd_done");
                cyc(rnd(), rnd(), v(S_WB_MEM, 2'b00, 2'b00, 2'b00, 0,0,0,0,0,1,1,0,0), "wb_mem");
            end
            3: begin
                cyc(rnd(), rnd(), v(S_MEM_ADDR, 2'b00, 2'b01, 2'b10, 0,0,0,0,0,0,0,0,0), "mem_addr");
                for (int i = 0; i < mwait; i++)
                    cyc(1'b0, rnd(), v(S_MEM_WR, 2'b00, 2'b00, 2'b00, 0,0,0,1,1,0,0,0,0), "mem_wr_wait");
                cyc(1'b1, rnd(), v(S_MEM_WR, 2'b00, 2'b00, 2'b00, 0,0,0,1,1,0,0,0,0), "mem_wr_done");
            end
            4: begin
                cyc(rnd(), z, v(S_BRANCH, 2'b01, 2'b01, 2'b00, z,1,0,0,0,0,0,0,0), "branch");
            end
            default: ;
        endcase
        if (kind != 5) model_instret = (model_instret + 1) % (1 << CW);
        check("instret", 32'(instret), 32'(model_instret));
    endtask

    initial begin
        do_reset();

        // Directed: R-type with immediate ready, load with waits, branch taken/not taken.
        run_instr(0, 0, 0, 1'b0);
        run_instr(2, 3, 2, 1'b0);
        run_instr(4, 0, 0, 1'b1);
        run_instr(4, 0, 0, 1'b0);
        // Longest legal waits: the 15th low cycle would expire, 14 must not.
        run_instr(2, MW - 1, MW - 1, 1'b0);
        run_instr(3, MW - 1, MW - 1, 1'b0);

        // Random mix; also wraps the 4-bit instret counter several times.
        for (int n = 0; n < 60; n++) begin
            int kind, fw, mw;
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 4);
`else
            kind = $urandom_range(0, 5);
`endif
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MW - 1) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MW - 1) : $urandom_range(0, 2);
            run_instr(kind, fw, mw, rnd());
        end

        // Illegal opcode 1111111.
        do_reset();
        run_instr(0, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        opcode = 7'b1111111;
        front_end(0);
        for (int i = 0; i < 3; i++)
            cyc(rnd(), rnd(), v(S_HALT, 2'b00, 2'b00, 2'b00, 0,0,0,0,0,0,0,1,0), "illegal_halt");
        check("illegal_instr", 32'(illegal_instr), 32'd1);
        check("illegal_instret", 32'(instret), 32'(model_instret));
`else
        opcode = 7'b1111111;
        front_end(0);
        check("illegal_instret", 32'(instret), 32'(model_instret));
        run_instr(1, 0, 0, 1'b0);
`endif

        // Watchdog: mem_ready never comes during FETCH.
        do_reset();
        opcode = 7'b0110011;
        for (int i = 0; i < MW; i++)
            cyc(1'b0, rnd(), v(S_FETCH, 2'b00, 2'b00, 2'b01, 0,0,0,1,0,0,0,0,0), "wd_fetch");
        for (int i = 0; i < 4; i++)
            cyc(rnd(), rnd(), v(S_HALT, 2'b00, 2'b00, 2'b00, 0,0,0,0,0,0,0,1,1), "wd_halt");
        check("wd_instret", 32'(instret), 32'd0);

        // Reset in the middle of a store wait.
        do_reset();
        opcode = 7'b0100011;
        front_end(0);
        cyc(1'b0, 1'b0, v(S_MEM_ADDR, 2'b00, 2'b01, 2'b10, 0,0,0,0,0,0,0,0,0), "rst_mem_addr");
        cyc(1'b0, 1'b0, v(S_MEM_WR, 2'b00, 2'b00, 2'b00, 0,0,0,1,1,0,0,0,0), "rst_mem_wr");
        #2 rst = 1'b1;
        #1 check("rst_mid_outputs", obs, 32'd0);
        check("rst_mid_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, v(S_FETCH, 2'b00, 2'b00, 2'b01, 0,0,0,1,0,0,0,0,0), "rst_after_fetch");
        check("rst_after_instret", 32'(instret), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
